// File: rtl/bakery_sched_pkg.sv
// Shared types and helpers for the bakery step scheduler.
// Holds the FSM state encoding, default sizing and index clamping.
package bakery_sched_pkg;

    localparam int N_DEFAULT     = 3;
    localparam int IDX_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PAUSE = 2'd3
    } sched_state_e;

    // Forces an out-of-range process index back to 0 so select can never exceed N-1.
    function automatic logic [7:0] clamp_idx(input logic [7:0] idx, input logic [7:0] n_lim);
        return (idx < n_lim) ? idx : 8'd0;
    endfunction

endpackage

// File: rtl/bakery_step_scheduler_rr_pick.sv
// Rotating-priority encoder: first requester strictly after the pointer,
// wrapping from N-1 back to 0.
module rr_pick
    import bakery_sched_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Keep the requester with the smallest rotated distance from the scan start.
    always_comb begin
        int w_start;
        int w_dist;
        int w_best;
        o_found = 1'b0;
        o_idx   = '0;
        w_dist  = 0;
        w_best  = N;
        w_start = (int'(i_ptr) >= N - 1) ? 0 : int'(i_ptr) + 1;
        for (int i = 0; i < N; i++) begin
            w_dist = (i >= w_start) ? (i - w_start) : (i + N - w_start);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end else begin
                w_best  = w_best;
            end
        end
    end

endmodule

// File: rtl/bakery_step_scheduler.sv
// Fair, bounded step scheduler for the N-process bakery model: picks one
// process per cycle or idles, with bounded pauses and critical-section holds.
module bakery_step_scheduler
    import bakery_sched_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int IDX_W     = IDX_W_DEFAULT,
    parameter int MAX_PAUSE = 4,
    parameter int CS_MAX    = 2,
    parameter int WAIT_MAX  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_crit,
    input  logic             i_pause_req,
    output logic [IDX_W-1:0] o_select,
    output logic             o_pause,
    output logic [IDX_W-1:0] o_sym_break,
    output logic             o_starve
);

    localparam int PC_W = $clog2(MAX_PAUSE + 1);
    localparam int HC_W = $clog2(CS_MAX + 1);
    localparam int WC_W = $clog2(WAIT_MAX + 2);

    localparam logic [PC_W-1:0] PC_MAX = PC_W'(MAX_PAUSE);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(CS_MAX);
    localparam logic [HC_W-1:0] HC_ONE = HC_W'(1);
    localparam logic [WC_W-1:0] WC_LIM = WC_W'(WAIT_MAX);
    localparam logic [WC_W-1:0] WC_SAT = WC_W'(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

    sched_state_e     r_state;
    logic [IDX_W-1:0] r_select;
    logic             r_pause;
    logic [IDX_W-1:0] r_sym_break;
    logic             r_starve;
    logic [PC_W-1:0]  r_pause_cnt;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [WC_W-1:0]  r_wait_cnt [N];

    sched_state_e     w_state_nxt;
    logic [IDX_W-1:0] w_select_nxt;
    logic             w_pause_nxt;
    logic [IDX_W-1:0] w_sym_break_nxt;
    logic             w_starve_nxt;
    logic [PC_W-1:0]  w_pause_cnt_nxt;
    logic [HC_W-1:0]  w_hold_cnt_nxt;
    logic [WC_W-1:0]  w_wait_nxt [N];

    logic             w_found;
    logic [IDX_W-1:0] w_pick_raw;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_crit;
    logic             w_sel_req;
    logic             w_sel_crit;
    logic             w_arb;
    logic             w_step;
    logic [IDX_W-1:0] w_step_idx;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_sym_break),
        .o_found (w_found),
        .o_idx   (w_pick_raw)
    );

    assign w_pick_idx = IDX_W'(clamp_idx(8'(w_pick_raw), 8'(N)));

    // Next-state, output and counter logic for all four scheduler states.
    always_comb begin
        w_state_nxt     = r_state;
        w_select_nxt    = r_select;
        w_pause_nxt     = r_pause;
        w_sym_break_nxt = r_sym_break;
        w_pause_cnt_nxt = r_pause_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_starve_nxt    = r_starve;
        w_sel_req       = 1'b0;
        w_sel_crit      = 1'b0;
        w_pick_crit     = 1'b0;
        w_arb           = 1'b0;
        w_step          = 1'b0;
        w_step_idx      = r_select;

        for (int i = 0; i < N; i++) begin
            if (r_select == IDX_W'(i)) begin
                w_sel_req  = i_req[i];
                w_sel_crit = i_crit[i];
            end else begin
                w_sel_req  = w_sel_req;
            end
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_crit = i_crit[i];
            end else begin
                w_pick_crit = w_pick_crit;
            end
        end

        case (r_state)
            ST_HOLD: begin
                // Leaving a hold arbitrates directly; a pending pause is not honoured here.
                if (w_sel_req && w_sel_crit && (r_hold_cnt < HC_MAX)) begin
                    w_hold_cnt_nxt = r_hold_cnt + HC_ONE;
                    w_pause_nxt    = 1'b0;
                    w_step         = 1'b1;
                    w_step_idx     = r_select;
                end else begin
                    w_arb = 1'b1;
                end
            end
            ST_IDLE, ST_GRANT, ST_PAUSE: begin
                if (i_req == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_pause_nxt = 1'b1;
                end else if (i_pause_req && (r_pause_cnt < PC_MAX)) begin
                    w_state_nxt     = ST_PAUSE;
                    w_pause_nxt     = 1'b1;
                    w_pause_cnt_nxt = r_pause_cnt + PC_ONE;
                end else begin
                    w_arb = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pause_nxt = 1'b1;
            end
        endcase

        if (w_arb) begin
            w_hold_cnt_nxt = '0;
            if (w_found) begin
                w_select_nxt    = w_pick_idx;
                w_sym_break_nxt = w_pick_idx;
                w_pause_nxt     = 1'b0;
                w_pause_cnt_nxt = '0;
                w_step          = 1'b1;
                w_step_idx      = w_pick_idx;
                if (w_pick_crit) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = HC_ONE;
                end else begin
                    w_state_nxt    = ST_GRANT;
                end
            end else begin
                w_state_nxt = ST_IDLE;
                w_pause_nxt = 1'b1;
            end
        end else begin
            w_arb = 1'b0;
        end

        for (int i = 0; i < N; i++) begin
            if (!i_req[i] || (w_step && (w_step_idx == IDX_W'(i)))) begin
                w_wait_nxt[i] = '0;
            end else if (r_wait_cnt[i] < WC_SAT) begin
                w_wait_nxt[i] = r_wait_cnt[i] + WC_ONE;
            end else begin
                w_wait_nxt[i] = r_wait_cnt[i];
            end
            if (w_wait_nxt[i] > WC_LIM) begin
                w_starve_nxt = 1'b1;
            end else begin
                w_starve_nxt = w_starve_nxt;
            end
        end
    end

    // State, output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_select    <= '0;
            r_pause     <= 1'b1;
            r_sym_break <= '0;
            r_starve    <= 1'b0;
            r_pause_cnt <= '0;
            r_hold_cnt  <= '0;
            for (int i = 0; i < N; i++) begin
                r_wait_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_select    <= w_select_nxt;
            r_pause     <= w_pause_nxt;
            r_sym_break <= w_sym_break_nxt;
            r_starve    <= w_starve_nxt;
            r_pause_cnt <= w_pause_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            for (int i = 0; i < N; i++) begin
                r_wait_cnt[i] <= w_wait_nxt[i];
            end
        end
    end

    assign o_select    = r_select;
    assign o_pause     = r_pause;
    assign o_sym_break = r_sym_break;
    assign o_starve    = r_starve;

endmodule

// File: tb/tb_bakery_step_scheduler.sv
// Directed and random stimulus against a behavioural scheduler model; a second
// instance with WAIT_MAX=2 exercises the starvation flag.
module tb_bakery_step_scheduler;

    localparam int N          = 3;
    localparam int IDX_W      = 3;
    localparam int MAX_PAUSE  = 4;
    localparam int CS_MAX     = 2;
    localparam int WAIT_MAX   = 16;
    localparam int WAIT_MAX_B = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = 3'b000;
    logic [N-1:0]     crit = 3'b000;
    logic             preq = 1'b0;
    logic [IDX_W-1:0] sel_a, sym_a, sel_b, sym_b;
    logic             pause_a, starve_a, pause_b, starve_b;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int m_sel, m_ptr, m_pause, m_pstreak, m_hold;
    int m_wait [N];
    int m_starve_a, m_starve_b;

    bakery_step_scheduler #(
        .N(N), .IDX_W(IDX_W), .MAX_PAUSE(MAX_PAUSE), .CS_MAX(CS_MAX), .WAIT_MAX(WAIT_MAX)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_crit(crit), .i_pause_req(preq),
        .o_select(sel_a), .o_pause(pause_a), .o_sym_break(sym_a), .o_starve(starve_a)
    );

    bakery_step_scheduler #(
        .N(N), .IDX_W(IDX_W), .MAX_PAUSE(MAX_PAUSE), .CS_MAX(CS_MAX), .WAIT_MAX(WAIT_MAX_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_crit(crit), .i_pause_req(preq),
        .o_select(sel_b), .o_pause(pause_b), .o_sym_break(sym_b), .o_starve(starve_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic model_reset();
        m_sel = 0; m_ptr = 0; m_pause = 1; m_pstreak = 0; m_hold = 0;
        m_starve_a = 0; m_starve_b = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    // One scheduling decision from the inputs present at the clock edge.
    task automatic model_step();
        int winner;
        bit arb;
        winner = -1;
        arb = 1'b0;
        if (m_hold > 0) begin
            if (bit_of(req, m_sel) && bit_of(crit, m_sel) && m_hold < CS_MAX) begin
                m_hold++;
                m_pause = 0;
                winner = m_sel;
            end else begin
                arb = 1'b1;
            end
        end else if (req == 3'b000) begin
            m_pause = 1;
        end else if (preq && m_pstreak < MAX_PAUSE) begin
            m_pause = 1;
            m_pstreak++;
        end else begin
            arb = 1'b1;
        end
        if (arb) begin
            m_hold = 0;
            if (req == 3'b000) begin
                m_pause = 1;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (winner < 0 && bit_of(req, (m_ptr + k) % N)) winner = (m_ptr + k) % N;
                m_sel = winner;
                m_ptr = winner;
                m_pause = 0;
                m_pstreak = 0;
                if (bit_of(crit, winner)) m_hold = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!bit_of(req, i) || winner == i) m_wait[i] = 0;
            else m_wait[i]++;
            if (m_wait[i] > WAIT_MAX) m_starve_a = 1;
            if (m_wait[i] > WAIT_MAX_B) m_starve_b = 1;
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] c, input logic p);
        @(negedge clk);
        req = r; crit = c; preq = p;
        @(posedge clk);
        model_step();
        #1;
        chk("select", 32'(sel_a), 32'(m_sel));
        chk("pause", 32'(pause_a), 32'(m_pause));
        chk("sym_break", 32'(sym_a), 32'(m_ptr));
        chk("starve", 32'(starve_a), 32'(m_starve_a));
        chk("select_b", 32'(sel_b), 32'(m_sel));
        chk("starve_b", 32'(starve_b), 32'(m_starve_b));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 3'b000; crit = 3'b000; preq = 1'b0;
        model_reset();
        #1;
        chk("rst_select", 32'(sel_a), 32'd0);
        chk("rst_pause", 32'(pause_a), 32'd1);
        chk("rst_sym_break", 32'(sym_a), 32'd0);
        chk("rst_starve_b", 32'(starve_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp1 [4];
        exp1 = '{1, 2, 0, 1};
        model_reset();
        repeat (2) @(posedge clk);

        // All requesting, no pauses: plain rotation
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(3'b111, 3'b000, 1'b0);
            chk("t1_sel_seq", 32'(sel_a), 32'(exp1[k]));
            chk("t1_pause", 32'(pause_a), 32'd0);
        end

        // Pause request held: four pauses, grant to 2, then a new pause episode
        do_reset();
        for (int k = 0; k < 11; k++) begin
            tick(3'b101, 3'b000, 1'b1);
            chk("t2_pause", 32'(pause_a), (k == 4 || k == 9) ? 32'd0 : 32'd1);
        end
        chk("t2_sel_after", 32'(sel_a), 32'd0);

        // Critical-section hold for process 1, pause request ignored during hold
        do_reset();
        tick(3'b011, 3'b010, 1'b0);
        chk("t3_hold1", 32'(sel_a), 32'd1);
        tick(3'b011, 3'b010, 1'b1);
        chk("t3_hold2", 32'(sel_a), 32'd1);
        tick(3'b011, 3'b010, 1'b1);
        chk("t3_release", 32'(sel_a), 32'd0);
        chk("t3_release_pause", 32'(pause_a), 32'd0);
        repeat (3) tick(3'b011, 3'b000, 1'b1);

        // Requests vanish from GRANT, then pause requests are honoured four times
        do_reset();
        repeat (2) tick(3'b111, 3'b000, 1'b0);
        repeat (3) tick(3'b000, 3'b000, 1'b1);
        chk("t4_frozen", 32'(sel_a), 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick(3'b111, 3'b000, 1'b1);
            chk("t4_pause", 32'(pause_a), (k < 4) ? 32'd1 : 32'd0);
        end

        // Long holds starve the other requesters of the WAIT_MAX=2 instance
        do_reset();
        repeat (8) tick(3'b111, 3'b011, 1'b0);
        chk("t5_starve_b", 32'(starve_b), 32'd1);
        chk("t5_starve_a", 32'(starve_a), 32'd0);
        repeat (4) tick(3'b000, 3'b000, 1'b0);
        chk("t5_sticky", 32'(starve_b), 32'd1);

        // Asynchronous reset in the middle of a hold
        do_reset();
        tick(3'b011, 3'b010, 1'b0);
        tick(3'b011, 3'b010, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_select", 32'(sel_a), 32'd0);
        chk("t6_pause", 32'(pause_a), 32'd1);
        chk("t6_sym_break", 32'(sym_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            tick(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
